// File: rtl/dual_port_mem_responder.sv
// Two-port word memory: read-only port 1, read/write port 2, each with its own LATENCY-cycle IDLE/BUSY/DONE responder.
// Optional macro WRITE_BYPASS_EN forwards a same-edge port-2 write to a colliding port-1 read.
module dual_port_mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM1,
    input  logic [WORD_SIZE-1:0] address1,
    output logic [WORD_SIZE-1:0] data1,
    output logic                 ready1,
    input  logic                 readM2,
    input  logic                 writeM2,
    input  logic [WORD_SIZE-1:0] address2,
    inout  wire  [WORD_SIZE-1:0] data2,
    output logic                 ready2
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

    state_t               st1, st1_nxt, st2, st2_nxt;
    logic [3:0]           cnt1, cnt1_nxt, cnt2, cnt2_nxt;
    logic                 take1, fin1, take2, fin2, req2;
    logic [ADDR_BITS-1:0] addr1_q, addr2_q, eaddr1, eaddr2;
    logic [WORD_SIZE-1:0] wdat2_q, ewdat2, rdat2_q, rd1_word;
    logic                 wr2_q, ewr2, commit;
    logic                 unused_hi;

    assign req2 = readM2 | writeM2;

    // In IDLE the request is being sampled this edge, so a LATENCY=1 completion must use the live inputs.
    assign eaddr1 = (st1 == IDLE) ? address1[ADDR_BITS-1:0] : addr1_q;
    assign eaddr2 = (st2 == IDLE) ? address2[ADDR_BITS-1:0] : addr2_q;
    assign ewr2   = (st2 == IDLE) ? writeM2 : wr2_q;
    assign ewdat2 = (st2 == IDLE) ? data2 : wdat2_q;
    assign commit = fin2 & ewr2 & ~reset;

`ifdef WRITE_BYPASS_EN
    assign rd1_word = (commit && (eaddr2 == eaddr1)) ? ewdat2 : mem[eaddr1];
`else
    assign rd1_word = mem[eaddr1];
`endif

    always_comb begin
        st1_nxt  = st1;
        cnt1_nxt = cnt1;
        take1    = 1'b0;
        fin1     = 1'b0;
        unique case (st1)
            IDLE: if (readM1) begin
                take1 = 1'b1;
                if (LATENCY == 1) begin
                    st1_nxt = DONE;
                    fin1    = 1'b1;
                end else begin
                    st1_nxt  = BUSY;
                    cnt1_nxt = CNT_INIT;
                end
            end
            BUSY: if (!readM1) begin
                st1_nxt  = IDLE;
                cnt1_nxt = '0;
            end else if (cnt1 == 4'd1) begin
                st1_nxt  = DONE;
                fin1     = 1'b1;
                cnt1_nxt = '0;
            end else begin
                cnt1_nxt = cnt1 - 4'd1;
            end
            default: st1_nxt = IDLE;
        endcase
    end

    always_comb begin
        st2_nxt  = st2;
        cnt2_nxt = cnt2;
        take2    = 1'b0;
        fin2     = 1'b0;
        unique case (st2)
            IDLE: if (req2) begin
                take2 = 1'b1;
                if (LATENCY == 1) begin
                    st2_nxt = DONE;
                    fin2    = 1'b1;
                end else begin
                    st2_nxt  = BUSY;
                    cnt2_nxt = CNT_INIT;
                end
            end
            BUSY: if (!req2) begin
                st2_nxt  = IDLE;
                cnt2_nxt = '0;
            end else if (cnt2 == 4'd1) begin
                st2_nxt  = DONE;
                fin2     = 1'b1;
                cnt2_nxt = '0;
            end else begin
                cnt2_nxt = cnt2 - 4'd1;
            end
            default: st2_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st1     <= IDLE;
            cnt1    <= '0;
            addr1_q <= '0;
            data1   <= '0;
        end else begin
            st1  <= st1_nxt;
            cnt1 <= cnt1_nxt;
            if (take1) addr1_q <= address1[ADDR_BITS-1:0];
            if (fin1)  data1   <= rd1_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st2     <= IDLE;
            cnt2    <= '0;
            addr2_q <= '0;
            wdat2_q <= '0;
            wr2_q   <= 1'b0;
            rdat2_q <= '0;
        end else begin
            st2  <= st2_nxt;
            cnt2 <= cnt2_nxt;
            if (take2) begin
                addr2_q <= address2[ADDR_BITS-1:0];
                wdat2_q <= data2;
                wr2_q   <= writeM2;
            end
            if (fin2 && !ewr2) rdat2_q <= mem[eaddr2];
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[eaddr2] <= ewdat2;
    end

    assign ready1 = (st1 == DONE);
    assign ready2 = (st2 == DONE);
    assign data2  = (st2 == DONE && !wr2_q) ? rdat2_q : {WORD_SIZE{1'bz}};

    assign unused_hi = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Bench for dual_port_mem_responder: directed scenarios with literal expectations, then random traffic
// on both ports checked every cycle against a transaction-level completion model.
module tb_dual_port_mem_responder;

    localparam int LAT = 2;
`ifdef WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        readM1 = 1'b0, readM2 = 1'b0, writeM2 = 1'b0;
    logic [15:0] address1 = '0, address2 = '0;
    logic [15:0] data1, tb_d2 = '0;
    logic        tb_d2_en = 1'b0;
    logic        ready1, ready2;
    wire  [15:0] data2;

    assign data2 = tb_d2_en ? tb_d2 : 16'bz;

    dual_port_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .readM1(readM1), .address1(address1), .data1(data1), .ready1(ready1),
        .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2), .ready2(ready2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        q1[$], q2[$];
    logic [15:0] mem_m [256];
    bit          known [256];
    logic [15:0] exp_d1 = '0;
    bit          exp_d1_known = 1'b1;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    logic [7:0]  lo_tab [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] undriven();
        return {15'd0, (data2 === 16'bz) || (data2 === 16'h0)};
    endfunction

    // Completion of a held request lands LAT cycles after the cycle it was first presented.
    task automatic p1_txn(input logic [15:0] a, input int hold);
        txn_t t;
        @(posedge clk); #1;
        if (hold >= LAT) begin
            t.done = cyc + LAT; t.wr = 1'b0; t.addr = a[7:0]; t.wdata = '0;
            q1.push_back(t);
        end
        readM1 = 1'b1; address1 = a;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            address1 = 16'($urandom);
        end
        @(posedge clk); #1;
        readM1 = 1'b0; address1 = 16'($urandom);
    endtask

    // op: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic p2_txn(input int op, input logic [15:0] a, input logic [15:0] wd, input int hold);
        txn_t t;
        @(posedge clk); #1;
        if (hold >= LAT) begin
            t.done = cyc + LAT; t.wr = (op != 0); t.addr = a[7:0]; t.wdata = wd;
            q2.push_back(t);
        end
        readM2 = (op != 1); writeM2 = (op != 0); address2 = a;
        if (op != 0) begin tb_d2 = wd; tb_d2_en = 1'b1; end
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            tb_d2_en = 1'b0; tb_d2 = 16'($urandom); address2 = 16'($urandom);
        end
        @(posedge clk); #1;
        readM2 = 1'b0; writeM2 = 1'b0; tb_d2_en = 1'b0; address2 = 16'($urandom);
    endtask

    always @(negedge clk) begin : monitor
        bit          er1, er2, d2_drv, d2_known;
        logic [15:0] d2_val;
        logic [7:0]  a;
        if (reset) begin
            q1.delete(); q2.delete();
            exp_d1 = '0; exp_d1_known = 1'b1;
            check("mon_rst_ready1", {15'd0, ready1}, 16'd0);
            check("mon_rst_ready2", {15'd0, ready2}, 16'd0);
            check("mon_rst_data1", data1, 16'h0000);
        end else begin
            er1 = (q1.size() > 0) && (q1[0].done == cyc);
            er2 = (q2.size() > 0) && (q2[0].done == cyc);
            d2_drv = 1'b0; d2_known = 1'b0; d2_val = '0;
            if (er2 && q2[0].wr && BYPASS) begin
                mem_m[q2[0].addr] = q2[0].wdata; known[q2[0].addr] = 1'b1;
            end
            if (er1) begin
                a = q1[0].addr;
                exp_d1 = mem_m[a]; exp_d1_known = known[a];
                void'(q1.pop_front());
            end
            if (er2) begin
                a = q2[0].addr;
                if (q2[0].wr) begin
                    if (!BYPASS) begin mem_m[a] = q2[0].wdata; known[a] = 1'b1; end
                end else begin
                    d2_drv = 1'b1; d2_known = known[a]; d2_val = mem_m[a];
                end
                void'(q2.pop_front());
            end
            check("mon_ready1", {15'd0, ready1}, {15'd0, er1});
            check("mon_ready2", {15'd0, ready2}, {15'd0, er2});
            if (exp_d1_known) check("mon_data1", data1, exp_d1);
            if (d2_drv) begin
                if (d2_known) check("mon_data2", data2, d2_val);
            end else if (!tb_d2_en) begin
                check("mon_data2_released", undriven(), 16'd1);
            end
        end
    end

    initial begin
        #3;
        check("rst_ready1", {15'd0, ready1}, 16'd0);
        check("rst_ready2", {15'd0, ready2}, 16'd0);
        check("rst_data1", data1, 16'h0000);
        check("rst_data2_released", undriven(), 16'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        p2_txn(1, 16'h0010, 16'h1234, LAT);
        check("wr_1234_ready2", {15'd0, ready2}, 16'd1);
        check("wr_1234_data2_released", undriven(), 16'd1);

        p1_txn(16'h0010, LAT);
        check("p1_rd_ready1", {15'd0, ready1}, 16'd1);
        check("p1_rd_data1", data1, 16'h1234);

        p2_txn(0, 16'h0010, 16'h0000, LAT);
        check("p2_rd_ready2", {15'd0, ready2}, 16'd1);
        check("p2_rd_data2", data2, 16'h1234);
        @(posedge clk); #1;
        check("p2_rd_data2_after", undriven(), 16'd1);

        if (LAT > 1) p1_txn(16'h0020, 1);
        repeat (3) @(posedge clk);
        #1 check("abort_data1_held", data1, 16'h1234);

        p2_txn(1, 16'h0030, 16'h0000, LAT);
        fork
            p1_txn(16'h0030, LAT);
            p2_txn(1, 16'h0030, 16'hBEEF, LAT);
        join
        check("collide_data1", data1, BYPASS ? 16'hBEEF : 16'h0000);
        p1_txn(16'h0030, LAT);
        check("collide_readback", data1, 16'hBEEF);

        p2_txn(1, 16'h0040, 16'h1111, LAT);
        if (LAT > 1) begin
            @(posedge clk); #1;
            writeM2 = 1'b1; address2 = 16'h0040; tb_d2 = 16'h5555; tb_d2_en = 1'b1;
            @(posedge clk); #1;
            tb_d2_en = 1'b0;
            #1 reset = 1'b1;
            @(posedge clk); #1;
            writeM2 = 1'b0;
            @(posedge clk); #2 reset = 1'b0;
        end
        p1_txn(16'h0040, LAT);
        check("rst_mid_write_readback", data1, 16'h1111);

        p2_txn(2, 16'h0050, 16'h00AA, LAT);
        check("both_ready2", {15'd0, ready2}, 16'd1);
        check("both_data2_released", undriven(), 16'd1);
        p1_txn(16'h0050, LAT);
        check("both_readback", data1, 16'h00AA);

        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    int h;
                    h = (LAT > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, LAT - 1) : LAT;
                    p1_txn({8'($urandom), lo_tab[$urandom_range(0, 4)]}, h);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    int h2;
                    h2 = (LAT > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, LAT - 1) : LAT;
                    p2_txn($urandom_range(0, 2), {8'($urandom), lo_tab[$urandom_range(0, 4)]},
                           16'($urandom), h2);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
